// File: rtl/difftest_hcsr_collector.sv
// Hypervisor/VS CSR snapshot collector feeding the difftest DPI sink.
// Captures the 17 CSR fields on each commit, delays them DELAY stages to line
// up with the instruction-commit stream, and forwards a snapshot only when the
// state changed, on the first commit after reset, or when a resync is due.
module difftest_hcsr_collector #(
  parameter int DELAY         = 2,
  parameter int SYNC_INTERVAL = 1024
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          io_csr_valid,
  input  logic [1087:0] io_csr_state,
  input  logic [7:0]    io_coreid,
  input  logic          io_flush,
  output logic          out_enable,
  output logic [1087:0] out_state,
  output logic [7:0]    out_coreid,
  output logic [31:0]   out_emit_count
);

  localparam int STATE_W = 17 * 64;

  // Resync threshold; only meaningful when SYNC_INTERVAL is non-zero.
  localparam logic [15:0] SYNC_THR = (SYNC_INTERVAL == 0) ? 16'd0 : 16'(SYNC_INTERVAL - 1);

  // Only bit 0 of virtMode carries information; upper bits are forced to zero
  // so spurious upper-bit noise never counts as a state change.
  function automatic logic [STATE_W-1:0] mask_virt(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] r;
    r        = s;
    r[63:1]  = '0;
    return r;
  endfunction

  logic [STATE_W-1:0] cap_state;
  logic               tail_valid;
  logic [STATE_W-1:0] tail_state;
  logic [7:0]         tail_coreid;
  logic               first_pending;
  logic [15:0]        sync_cnt;
  logic               sync_due;
  logic               emit;

  assign cap_state = mask_virt(io_csr_state);

  generate
    if (DELAY == 0) begin : g_nodelay
      assign tail_valid  = io_csr_valid;
      assign tail_state  = cap_state;
      assign tail_coreid = io_coreid;
    end else begin : g_delay
      logic [DELAY-1:0]   vld_p;
      logic [STATE_W-1:0] state_p  [DELAY];
      logic [7:0]         coreid_p [DELAY];

      // Valid bits shift every cycle; a flush kills everything in flight,
      // including the sample presented in the flush cycle.
      always_ff @(posedge clock) begin
        if (reset || io_flush) begin
          vld_p <= '0;
        end else begin
          vld_p[0] <= io_csr_valid;
          for (int i = 1; i < DELAY; i++) begin
            vld_p[i] <= vld_p[i-1];
          end
        end
      end

      // Stage data: stage 0 captures on commit, later stages advance freely.
      always_ff @(posedge clock) begin
        if (io_csr_valid) begin
          state_p[0]  <= cap_state;
          coreid_p[0] <= io_coreid;
        end
        for (int i = 1; i < DELAY; i++) begin
          state_p[i]  <= state_p[i-1];
          coreid_p[i] <= coreid_p[i-1];
        end
      end

      assign tail_valid  = vld_p[DELAY-1];
      assign tail_state  = state_p[DELAY-1];
      assign tail_coreid = coreid_p[DELAY-1];
    end
  endgenerate

  // ---- compare stage: tail against last emitted snapshot ----
  // out_state/out_coreid always equal the last emitted snapshot (both reset
  // to zero and both load on emit), so they double as the change shadow.
  assign sync_due = (SYNC_INTERVAL != 0) && (sync_cnt >= SYNC_THR);
  assign emit     = tail_valid && !io_flush &&
                    (first_pending || sync_due ||
                     (tail_state != out_state) || (tail_coreid != out_coreid));

  // ---- output stage: registered snapshot, pulse, counters ----
  // Emission bookkeeping: snapshot/shadow update, pulse, counters, resync timer.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_enable     <= 1'b0;
      out_state      <= '0;
      out_coreid     <= '0;
      out_emit_count <= '0;
      first_pending  <= 1'b1;
      sync_cnt       <= '0;
    end else begin
      out_enable <= emit;
      if (emit) begin
        out_state      <= tail_state;
        out_coreid     <= tail_coreid;
        out_emit_count <= out_emit_count + 32'd1;
        first_pending  <= 1'b0;
        sync_cnt       <= '0;
      end else if (sync_cnt != 16'hFFFF) begin
        sync_cnt <= sync_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_difftest_hcsr_collector.sv
// Scoreboard bench for difftest_hcsr_collector: directed commits push the
// expected snapshot (cycle, state, coreid, count) into a queue; a negedge
// monitor pops and compares on every out_enable pulse.
module tb_difftest_hcsr_collector;

  logic          clock;
  logic          reset;
  logic          io_csr_valid;
  logic [1087:0] io_csr_state;
  logic [7:0]    io_coreid;
  logic          io_flush;
  logic          out_enable;
  logic [1087:0] out_state;
  logic [7:0]    out_coreid;
  logic [31:0]   out_emit_count;
  logic          ns_enable;
  logic [1087:0] ns_state;
  logic [7:0]    ns_coreid;
  logic [31:0]   ns_emit_count;

  difftest_hcsr_collector #(.DELAY(2), .SYNC_INTERVAL(8)) u_dut (
    .clock(clock), .reset(reset), .io_csr_valid(io_csr_valid),
    .io_csr_state(io_csr_state), .io_coreid(io_coreid), .io_flush(io_flush),
    .out_enable(out_enable), .out_state(out_state), .out_coreid(out_coreid),
    .out_emit_count(out_emit_count)
  );

  difftest_hcsr_collector #(.DELAY(2), .SYNC_INTERVAL(0)) u_nosync (
    .clock(clock), .reset(reset), .io_csr_valid(io_csr_valid),
    .io_csr_state(io_csr_state), .io_coreid(io_coreid), .io_flush(io_flush),
    .out_enable(ns_enable), .out_state(ns_state), .out_coreid(ns_coreid),
    .out_emit_count(ns_emit_count)
  );

  typedef struct {
    int unsigned   cyc;
    logic [1087:0] st;
    logic [7:0]    cid;
    logic [31:0]   cnt;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_miss = 0;
  logic [31:0] exp_cnt = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [1087:0] mk(input int idx, input logic [63:0] v);
    logic [1087:0] r;
    r = '0;
    r[idx*64 +: 64] = v;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the head of the expected queue.
  always @(negedge clock) begin
    if (out_enable === 1'b1) begin
      if (q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_enable: pulse at cycle %0d count=%0d, expected no pulse", cyc, out_emit_count);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("emit_cycle", 64'(cyc), 64'(e.cyc));
        chk("emit_coreid", 64'(out_coreid), 64'(e.cid));
        chk("emit_count", 64'(out_emit_count), 64'(e.cnt));
        n_vec++;
        if (out_state !== e.st) begin
          n_miss++;
          for (int f = 0; f < 17; f++) begin
            if (out_state[f*64 +: 64] !== e.st[f*64 +: 64])
              $display("FAIL emit_state field %0d: got 0x%0h, expected 0x%0h", f,
                       out_state[f*64 +: 64], e.st[f*64 +: 64]);
          end
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [1087:0] st, input logic [7:0] cid, input logic fl);
    io_csr_valid = v;
    io_csr_state = st;
    io_coreid    = cid;
    io_flush     = fl;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 8'd0, 1'b0);
  endtask

  // Expected output appears DELAY+1 = 3 cycles after the commit cycle.
  task automatic push_exp(input int unsigned t, input logic [1087:0] st, input logic [7:0] cid);
    exp_t e;
    exp_cnt++;
    e.cyc = t + 3;
    e.st  = st;
    e.cid = cid;
    e.cnt = exp_cnt;
    q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, '0, 8'd0, 1'b0);
    drive(1'b0, '0, 8'd0, 1'b0);
    chk("reset_enable", 64'(out_enable), 64'd0);
    chk("reset_state_or", 64'(|out_state), 64'd0);
    chk("reset_coreid", 64'(out_coreid), 64'd0);
    chk("reset_count", 64'(out_emit_count), 64'd0);
    reset = 1'b0;
    exp_cnt = 0;
  endtask

  logic [1087:0] s_a;
  logic [1087:0] s_b;

  initial begin
    reset        = 1'b1;
    io_csr_valid = 1'b0;
    io_csr_state = '0;
    io_coreid    = '0;
    io_flush     = 1'b0;
    #1;

    // Single all-zero commit: emits once through first_pending.
    do_reset();
    push_exp(cyc, '0, 8'd0);
    drive(1'b1, '0, 8'd0, 1'b0);
    idle(6);
    chk("t1_count", 64'(out_emit_count), 64'd1);

    // Identical commits collapse to one emit; a change emits again.
    do_reset();
    s_a = mk(12, 64'h8000_1000);
    s_b = mk(12, 64'h8000_1004);
    push_exp(cyc, s_a, 8'd3);
    for (int k = 0; k < 5; k++) drive(1'b1, s_a, 8'd3, 1'b0);
    push_exp(cyc, s_b, 8'd3);
    drive(1'b1, s_b, 8'd3, 1'b0);
    idle(5);
    chk("t2_vsepc_hold", out_state[12*64 +: 64], 64'h8000_1004);
    chk("t2_count", 64'(out_emit_count), 64'd2);

    // Flush kills an in-flight sample and a same-cycle commit.
    do_reset();
    drive(1'b1, mk(14, 64'hDEAD), 8'd1, 1'b0);
    drive(1'b0, '0, 8'd0, 1'b1);
    idle(1);
    drive(1'b1, mk(14, 64'hCAFE), 8'd1, 1'b1);
    idle(6);
    chk("t3_count_after_flush", 64'(out_emit_count), 64'd0);
    push_exp(cyc, mk(14, 64'hBEEF), 8'd2);
    drive(1'b1, mk(14, 64'hBEEF), 8'd2, 1'b0);
    idle(5);
    chk("t3_count_after_commit", 64'(out_emit_count), 64'd1);

    // Periodic resync with SYNC_INTERVAL=8; the SYNC_INTERVAL=0 copy stays at one.
    do_reset();
    s_a = mk(3, 64'h55);
    for (int k = 0; k < 26; k++) begin
      if (k % 8 == 0) push_exp(cyc, s_a, 8'd1);
      drive(1'b1, s_a, 8'd1, 1'b0);
    end
    idle(5);
    chk("t4_sync_count", 64'(out_emit_count), 64'd4);
    chk("t4_nosync_count", 64'(ns_emit_count), 64'd1);

    // virtMode masking: upper bits are ignored, bit 0 is significant.
    do_reset();
    push_exp(cyc, '0, 8'd0);
    drive(1'b1, mk(0, 64'hFFFF_FFFF_FFFF_FFFE), 8'd0, 1'b0);
    drive(1'b1, '0, 8'd0, 1'b0);
    push_exp(cyc, mk(0, 64'h1), 8'd0);
    drive(1'b1, mk(0, 64'h1), 8'd0, 1'b0);
    idle(5);
    chk("t5_virt_field", out_state[63:0], 64'h1);
    chk("t5_count", 64'(out_emit_count), 64'd2);

    // Reset while a sample is in stage 1: discarded, next commit still emits.
    drive(1'b1, mk(7, 64'h1234), 8'd5, 1'b0);
    idle(1);
    reset = 1'b1;
    drive(1'b0, '0, 8'd0, 1'b0);
    reset = 1'b0;
    exp_cnt = 0;
    chk("t6_reset_enable", 64'(out_enable), 64'd0);
    chk("t6_reset_count", 64'(out_emit_count), 64'd0);
    idle(4);
    chk("t6_no_emit", 64'(out_emit_count), 64'd0);
    push_exp(cyc, '0, 8'd0);
    drive(1'b1, '0, 8'd0, 1'b0);
    idle(5);
    chk("t6_count", 64'(out_emit_count), 64'd1);

    chk("pending_expectations", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
